// File: rtl/haar_dwt_ml_if.sv
// Streaming interface for haar_dwt_ml: sample input side, coefficient output side, status.
// Latency: none (wires only).
// Backpressure: din_valid/din_ready on the input, dout_valid/dout_ready on the output.
// Ports: din/din_valid/din_ready/levels (sample side), dout/dout_valid/dout_ready/
//        dout_detail/dout_level/dout_last (coefficient side), busy (status).
interface haar_dwt_ml_if #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEVELS = 3
);
    localparam int LW = $clog2(MAX_LEVELS + 1);

    logic signed [DATA_WIDTH-1:0] din;
    logic                         din_valid;
    logic                         din_ready;
    logic [LW-1:0]                levels;
    logic signed [DATA_WIDTH-1:0] dout;
    logic                         dout_valid;
    logic                         dout_ready;
    logic                         dout_detail;
    logic [LW-1:0]                dout_level;
    logic                         dout_last;
    logic                         busy;

    // master: the side that feeds samples and consumes coefficients
    modport master (
        output din, din_valid, levels, dout_ready,
        input  din_ready, dout, dout_valid, dout_detail, dout_level, dout_last, busy
    );

    // slave: the transform block itself
    modport slave (
        input  din, din_valid, levels, dout_ready,
        output din_ready, dout, dout_valid, dout_detail, dout_level, dout_last, busy
    );
endinterface

// File: rtl/haar_dwt_ml.sv
// Frame-based multi-level signed Haar DWT; coefficients streamed out in Mallat order.
// Latency: N-(N>>L) compute cycles after the last sample, then one coefficient per accepted beat.
// Backpressure: din_ready only in LOAD; dout held stable while dout_ready=0.
// Ports: clk, rst (async, active-high), bus (haar_dwt_ml_if.slave: sample side, coefficient side, busy).
module haar_dwt_ml #(
    parameter int DATA_WIDTH    = 8,
    parameter int SIGNAL_LENGTH = 8,
    parameter int MAX_LEVELS    = 3
) (
    input  logic          clk,
    input  logic          rst,
    haar_dwt_ml_if.slave  bus
);
    localparam int N  = SIGNAL_LENGTH;
    localparam int KW = $clog2(N);
    localparam int LW = $clog2(MAX_LEVELS + 1);

    typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

    state_t state, state_nxt;

    logic [KW-1:0] in_cnt;     // sample write index during LOAD
    logic [KW-1:0] pair_k;     // pair index within the current level
    logic [KW-1:0] out_idx;    // coefficient index during OUTPUT
    logic [LW-1:0] lvl_eff;    // clamped depth latched with the first sample
    logic [LW-1:0] lvl_done;   // levels fully computed so far

    // smp holds samples, then approximations in place; det holds details by Mallat index
    logic signed [DATA_WIDTH-1:0] smp [N];
    logic signed [DATA_WIDTH-1:0] det [N];

    logic [LW-1:0]   lvl_clamped;
    logic [KW-1:0]   half;      // M/2 for the current level
    logic [KW-1:0]   i0, i1;
    logic            pair_last;
    logic            last_level;
    logic [KW-1:0]   n_approx;
    logic            in_beat, out_beat;
    logic [DATA_WIDTH:0] sum, dif;

    always_comb begin
        lvl_clamped = bus.levels;
        if (bus.levels == '0)
            lvl_clamped = LW'(1);
        else if (bus.levels > LW'(MAX_LEVELS))
            lvl_clamped = LW'(MAX_LEVELS);
    end

    assign half       = KW'(N >> (int'(lvl_done) + 1));
    assign pair_last  = (pair_k == half - KW'(1));
    assign last_level = (lvl_done + LW'(1) == lvl_eff);
    assign n_approx   = KW'(N >> lvl_eff);
    assign i0         = KW'({pair_k, 1'b0});
    assign i1         = i0 + KW'(1);
    assign in_beat    = (state == LOAD) && bus.din_valid;
    assign out_beat   = (state == OUTPUT) && bus.dout_ready;

    // Extend by one bit so sum/difference never wrap; dropping bit 0 is the >>>1.
    assign sum = {smp[i0][DATA_WIDTH-1], smp[i0]} + {smp[i1][DATA_WIDTH-1], smp[i1]};
    assign dif = {smp[i0][DATA_WIDTH-1], smp[i0]} - {smp[i1][DATA_WIDTH-1], smp[i1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_beat && in_cnt == KW'(N - 1)) state_nxt = COMPUTE;
            COMPUTE: if (pair_last && last_level)         state_nxt = OUTPUT;
            OUTPUT:  if (out_beat && out_idx == KW'(N - 1)) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Counters rely on the power-of-two frame length to wrap back to zero on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt   <= '0;
            pair_k   <= '0;
            out_idx  <= '0;
            lvl_eff  <= '0;
            lvl_done <= '0;
        end else begin
            case (state)
                LOAD: if (in_beat) begin
                    in_cnt <= in_cnt + KW'(1);
                    if (in_cnt == '0)
                        lvl_eff <= lvl_clamped;
                end
                COMPUTE: if (pair_last) begin
                    pair_k   <= '0;
                    lvl_done <= last_level ? '0 : lvl_done + LW'(1);
                end else begin
                    pair_k <= pair_k + KW'(1);
                end
                OUTPUT: if (out_beat)
                    out_idx <= out_idx + KW'(1);
                default: ;
            endcase
        end
    end

    // In-place write of smp[k] is safe: later pairs of this level read indices >= 2k+2.
    always_ff @(posedge clk) begin
        if (in_beat)
            smp[in_cnt] <= bus.din;
        if (state == COMPUTE) begin
            smp[pair_k]        <= sum[DATA_WIDTH:1];
            det[half + pair_k] <= dif[DATA_WIDTH:1];
        end
    end

    assign bus.din_ready  = (state == LOAD);
    assign bus.dout_valid = (state == OUTPUT);
    assign bus.busy       = (state != LOAD) || (in_cnt != '0);

    // Output is a direct read of the buffers, so it holds for free while stalled.
    always_comb begin
        int oi;
        oi              = int'(out_idx);
        bus.dout        = '0;
        bus.dout_detail = 1'b0;
        bus.dout_level  = '0;
        bus.dout_last   = 1'b0;
        if (state == OUTPUT) begin
            bus.dout_last = (out_idx == KW'(N - 1));
            if (out_idx < n_approx) begin
                bus.dout       = smp[out_idx];
                bus.dout_level = lvl_eff;
            end else begin
                bus.dout        = det[out_idx];
                bus.dout_detail = 1'b1;
                // Sub-band [N>>l, N>>(l-1)) belongs to level l.
                for (int l = 1; l <= MAX_LEVELS; l++) begin
                    if (oi >= (N >> l) && oi < (N >> (l - 1)))
                        bus.dout_level = LW'(l);
                end
            end
        end
    end
endmodule

// File: tb/tb_haar_dwt_ml.sv
// Randomized scoreboard bench for haar_dwt_ml against an arithmetic Haar model.
// Latency: checks compute duration N-(N>>L) from last sample to first coefficient.
// Backpressure: random dout_ready and din_valid gaps; checks hold stability and din_ready stall.
module tb_haar_dwt_ml;
    localparam int DW = 8;
    localparam int N  = 8;
    localparam int ML = 3;
    localparam int LW = $clog2(ML + 1);

    logic clk;
    logic rst;

    haar_dwt_ml_if #(.DATA_WIDTH(DW), .MAX_LEVELS(ML)) io();

    haar_dwt_ml #(.DATA_WIDTH(DW), .SIGNAL_LENGTH(N), .MAX_LEVELS(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (io)
    );

    typedef struct {
        int val;
        bit det;
        int lvl;
        bit last;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   got = 0;
    int   exp_dur = 0;
    int   frames_sent = 0;
    int   frames_done = 0;
    bit   rdy_rand = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: repeated pairwise average/half-difference on plain integer arrays.
    task automatic model(input int s[N], input int lv);
        int x[N];
        int dt[N];
        int t[N];
        int L, m, fl;
        exp_t e;
        L = (lv < 1) ? 1 : (lv > ML) ? ML : lv;
        x = s;
        dt = '{default: 0};
        for (int l = 1; l <= L; l++) begin
            m = N >> (l - 1);
            t = x;
            for (int k = 0; k < m / 2; k++) begin
                x[k]          = (t[2*k] + t[2*k+1]) >>> 1;
                dt[m / 2 + k] = (t[2*k] - t[2*k+1]) >>> 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i < (N >> L)) begin
                e.val = x[i]; e.det = 1'b0; e.lvl = L;
            end else begin
                fl = 0;
                while ((2 << fl) <= i) fl++;
                e.val = dt[i]; e.det = 1'b1; e.lvl = $clog2(N) - fl;
            end
            e.last = (i == N - 1);
            expq.push_back(e);
        end
        exp_dur = N - (N >> L);
    endtask

    task automatic send_frame(input int s[N], input int lv, input bit gaps, input bit toggle);
        bit acc;
        int t;
        model(s, lv);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                io.din_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            io.din       = DW'(s[i]);
            io.levels    = (i == 0 || !toggle) ? LW'(lv) : LW'($urandom);
            io.din_valid = 1'b1;
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = io.din_ready;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) chk("din_accept_timeout", 0, 1);
        end
        io.din_valid = 1'b0;
        frames_sent++;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((frames_sent != frames_done || expq.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("frame_leftover", expq.size() + (frames_sent - frames_done), 0);
        @(posedge clk);
        #1;
        chk("idle_din_ready", int'(io.din_ready), 1);
        chk("idle_dout_valid", int'(io.dout_valid), 0);
        chk("idle_busy", int'(io.busy), 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dout_valid"}, int'(io.dout_valid), 0);
        chk({tag, "_dout"}, int'(io.dout), 0);
        chk({tag, "_din_ready"}, int'(io.din_ready), 1);
        chk({tag, "_detail"}, int'(io.dout_detail), 0);
        chk({tag, "_level"}, int'(io.dout_level), 0);
        chk({tag, "_last"}, int'(io.dout_last), 0);
        chk({tag, "_busy"}, int'(io.busy), 0);
    endtask

    // Downstream ready, changed only just after the active edge.
    initial begin
        io.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            io.dout_ready = rdy_rand ? 1'($urandom) : 1'b1;
        end
    end

    // Monitor: pops expected coefficients on accepted beats, checks holds and stall.
    initial begin
        exp_t e;
        bit   have_hold;
        bit   seen_first;
        int   wait_cnt;
        int   h_dout, h_det, h_lvl, h_last;
        have_hold = 1'b0;
        seen_first = 1'b0;
        wait_cnt = 0;
        h_dout = 0; h_det = 0; h_lvl = 0; h_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_hold = 1'b0;
                seen_first = 1'b0;
                wait_cnt = 0;
                continue;
            end
            if (frames_sent != frames_done) begin
                chk("din_ready_stall", int'(io.din_ready), 0);
                if (!io.dout_valid && !seen_first) wait_cnt++;
            end
            if (have_hold) begin
                chk("hold_valid", int'(io.dout_valid), 1);
                chk("hold_dout", int'(io.dout), h_dout);
                chk("hold_detail", int'(io.dout_detail), h_det);
                chk("hold_level", int'(io.dout_level), h_lvl);
                chk("hold_last", int'(io.dout_last), h_last);
                have_hold = 1'b0;
            end
            if (io.dout_valid) begin
                if (!seen_first && frames_sent != frames_done) begin
                    chk("compute_cycles", wait_cnt, exp_dur);
                    seen_first = 1'b1;
                end
                if (io.dout_ready) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_coef", int'(io.dout), 9999);
                    end else begin
                        e = expq.pop_front();
                        chk("dout", int'(io.dout), e.val);
                        chk("dout_detail", int'(io.dout_detail), int'(e.det));
                        chk("dout_level", int'(io.dout_level), e.lvl);
                        chk("dout_last", int'(io.dout_last), int'(e.last));
                    end
                    got++;
                    if (io.dout_last) begin
                        frames_done++;
                        seen_first = 1'b0;
                        wait_cnt = 0;
                    end
                end else begin
                    have_hold = 1'b1;
                    h_dout = int'(io.dout);
                    h_det  = int'(io.dout_detail);
                    h_lvl  = int'(io.dout_level);
                    h_last = int'(io.dout_last);
                end
            end
        end
    end

    initial begin
        int fa[N];
        int fx[N];
        int fr[N];
        int g0, t;
        fa = '{10, 20, 30, 40, -8, -4, 5, 5};
        fx = '{127, 127, 127, -128, -128, 127, -128, -128};
        io.din = '0;
        io.din_valid = 1'b0;
        io.levels = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #2 check_reset("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        send_frame(fa, 1, 0, 0); wait_done();
        send_frame(fa, 3, 0, 0); wait_done();
        send_frame(fx, 1, 0, 0); wait_done();
        send_frame(fa, 0, 0, 0); wait_done();
        send_frame(fa, 7, 0, 0); wait_done();
        send_frame(fa, 3, 0, 1); wait_done();
        send_frame(fa, 2, 1, 1); wait_done();
        rdy_rand = 1'b1;
        send_frame(fa, 3, 0, 0); wait_done();
        for (int f = 0; f < 8; f++) begin
            foreach (fr[i]) fr[i] = int'($urandom_range(0, 255)) - 128;
            send_frame(fr, int'($urandom_range(0, 3)), 1, 1);
            wait_done();
        end
        rdy_rand = 1'b0;

        // Abort in OUTPUT after three coefficients have been accepted.
        send_frame(fa, 3, 0, 0);
        g0 = got;
        t = 0;
        while (got < g0 + 3 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("pre_abort_count", got - g0, 3);
        #2 rst = 1'b1;
        #1 check_reset("abort");
        expq.delete();
        frames_sent = frames_done;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_abort_idle", int'(io.dout_valid), 0);
        end
        @(posedge clk);
        #1;
        fr = '{-100, 50, 3, -3, 64, 64, -1, 0};
        send_frame(fr, 3, 0, 0); wait_done();
        send_frame(fa, 1, 0, 0); wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/haar_dwt_ml.md
Name: haar_dwt_ml

Overview:
- Frame-based, multi-level, signed Haar DWT with valid/ready streaming on both sides.
- Accepts SIGNAL_LENGTH samples per frame and runs a runtime-selectable number of decomposition levels, one pair per cycle, in place.
- Streams the coefficients out in Mallat order: final approximation first, then details from coarsest to finest.
- Sits between the sample-capture front end and downstream thresholding/compression stages.

Parameters:
- DATA_WIDTH, 8, sample and coefficient width; two's-complement signed.
- SIGNAL_LENGTH, 8, samples per frame; power of 2, ≥2.
- MAX_LEVELS, 3, maximum decomposition depth; 1 ≤ MAX_LEVELS ≤ log2(SIGNAL_LENGTH).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- din  input  DATA_WIDTH  signed input sample
- din_valid  input  1  input sample valid
- din_ready  output  1  block can accept a sample
- levels  input  $clog2(MAX_LEVELS+1)  requested decomposition depth; sampled with the first sample of a frame
- dout  output  DATA_WIDTH  signed coefficient
- dout_valid  output  1  coefficient valid
- dout_ready  input  1  downstream accepts the coefficient
- dout_detail  output  1  0 = approximation coefficient, 1 = detail coefficient
- dout_level  output  $clog2(MAX_LEVELS+1)  level of the coefficient (1 = finest); approximation carries the effective depth
- dout_last  output  1  last coefficient of the frame
- busy  output  1  state is not LOAD, or at least one sample of the current frame has been accepted

Behaviour:
- Reset values (async): state=LOAD; counters=0; din_ready=1; dout_valid=0; dout=0; dout_detail=0; dout_level=0; dout_last=0; busy=0. Buffer contents are don't-care.
- Effective depth L is latched on the first accepted sample of a frame:
  - L = levels, clamped to the range 1..MAX_LEVELS;
  - levels=0 gives L=1;
  - levels>MAX_LEVELS gives L=MAX_LEVELS.
- LOAD state:
  - din_ready=1.
  - Each din_valid&din_ready beat writes buf[k]=din, with k counting 0..N-1 in arrival order.
  - The beat with k=N-1 moves the state to COMPUTE.
- COMPUTE state (din_ready=0):
  - For level l=1..L, working length M=N>>(l-1).
  - One pair per cycle, k=0..M/2-1:
    - a = (buf[2k]+buf[2k+1])>>>1
    - d = (buf[2k]-buf[2k+1])>>>1
    - Sum and difference are computed at DATA_WIDTH+1 bits, then arithmetic-shifted; the result always fits DATA_WIDTH with no saturation.
  - Writes are buf[k]=a and det[M/2+k]=d.
    - In-place writes to buf are safe because later reads use indices ≥2k+2.
    - det is a separate array.
  - Duration is exactly N-(N>>L) cycles. The state then moves to OUTPUT.
- OUTPUT state (din_ready=0):
  - Emits N coefficients in this order:
    - buf[0..(N>>L)-1], with dout_detail=0 and dout_level=L;
    - then det[i] for i=N>>L..N-1, with dout_detail=1 and dout_level=log2(N/i') for the sub-band containing i (i in [N>>l, N>>(l-1)) gives level l).
  - dout_valid is asserted the cycle after COMPUTE ends.
  - A beat completes on dout_valid&dout_ready.
  - While dout_ready=0, dout, dout_detail, dout_level and dout_last hold stable and dout_valid stays 1.
  - dout_last=1 only on coefficient N-1.
  - When the last beat completes, the state returns to LOAD. din_ready is 1 on the next cycle, and dout_valid drops unless a new frame is ready.
- No overlap between frames: input stalls during COMPUTE and OUTPUT.
- Changes on levels after the first accepted sample have no effect on the current frame.
- Reset asserted mid-frame (any state) aborts the frame immediately; no partial output is produced after reset release.

Test Plan:
- Use N=8, DATA_WIDTH=8. Feed 10,20,30,40,-8,-4,5,5 with levels=1 → 4-cycle COMPUTE, then dout=15,35,-6,5,-5,-5,-2,0; detail flags 0,0,0,0,1,1,1,1; dout_level=1 throughout; dout_last on the 8th coefficient.
- Same input, levels=3 → 7-cycle COMPUTE, then dout=12,13,-10,-6,-5,-5,-2,0; dout_level=3,3,2,2,1,1,1,1; detail flag 0 only on the first coefficient.
- Extremes, levels=1: pairs (127,127),(127,-128),(-128,127),(-128,-128) → a=127,-1,-1,-128 and d=0,127,-128,0; no wrap.
- Clamp check: levels=0 → identical to the levels=1 result. levels=7 (MAX_LEVELS=3) → identical to the levels=3 result. Toggle levels mid-frame → no change to the result.
- Backpressure: random dout_ready (about 50%) on the levels=3 frame → same 8-value sequence, outputs stable while stalled. Random din_valid gaps → result unchanged. din_ready=0 throughout COMPUTE and OUTPUT.
- Reset mid-OUTPUT, after 3 coefficients → outputs return to reset values asynchronously. A following full frame produces correct, complete output with no leftover coefficients.
